fft_bfly_pipe: RTL and testbench

- Parametrised, pipelined radix-2 complex butterfly for the systolic FFT array; successor to the combinational butterfly.
- Supports DIT and DIF in one block, selected per transaction.
- Adds fixed-point rounding, optional per-transaction scale-by-2, overflow flagging and valid/ready flow control.
- Instantiated once per stage column; stages chain output-to-input.

---
 rtl/fft_pkg.sv | 33 +++
 rtl/fft_bfly_pipe_cmul_round.sv | 54 +++++
 rtl/fft_bfly_pipe.sv | 240 ++++++++++++++++++++++++
 tb/tb_fft_bfly_pipe.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT encodings, latency constant and narrowing helpers.
// Helpers operate on 32-bit signed values, so callers need DW+3 <= 32.
package fft_pkg;

  localparam logic BFLY_DIT = 1'b0;
  localparam logic BFLY_DIF = 1'b1;
  localparam int   BFLY_LAT = 3;

  function automatic logic signed [31:0] sat_narrow(input logic signed [31:0] value,
                                                    input int                 dw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (dw - 1));
    if (value > hi) begin
      sat_narrow = hi;
    end else if (value < lo) begin
      sat_narrow = lo;
    end else begin
      sat_narrow = value;
    end
  endfunction

  function automatic logic out_of_range(input logic signed [31:0] value,
                                        input int                 dw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (dw - 1));
    out_of_range = (value > hi) || (value < lo);
  endfunction

endpackage

// File: rtl/fft_bfly_pipe_cmul_round.sv
// rtl/fft_bfly_pipe_cmul_round.sv - registered complex multiply c*w, round-half-up by FRAC.
// Result is truncated to OW bits; enable freezes the register during a stall.
module cmul_round #(
  parameter int CW   = 17,
  parameter int TWW  = 16,
  parameter int FRAC = 15,
  parameter int OW   = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic signed [CW-1:0]  c_re,
  input  logic signed [CW-1:0]  c_im,
  input  logic signed [TWW-1:0] w_re,
  input  logic signed [TWW-1:0] w_im,
  output logic signed [OW-1:0]  p_re,
  output logic signed [OW-1:0]  p_im
);

  localparam int PW = CW + TWW + 1;
  localparam logic signed [PW-1:0] RND = PW'(1) <<< (FRAC - 1);

  logic signed [PW-1:0] re_full;
  logic signed [PW-1:0] im_full;
  logic signed [OW-1:0] p_re_d;
  logic signed [OW-1:0] p_re_q;
  logic signed [OW-1:0] p_im_d;
  logic signed [OW-1:0] p_im_q;

  always_comb begin
    re_full = PW'(c_re) * PW'(w_re) - PW'(c_im) * PW'(w_im);
    im_full = PW'(c_re) * PW'(w_im) + PW'(c_im) * PW'(w_re);
    p_re_d  = p_re_q;
    p_im_d  = p_im_q;
    if (en) begin
      p_re_d = OW'((re_full + RND) >>> FRAC);
      p_im_d = OW'((im_full + RND) >>> FRAC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_re_q <= '0;
      p_im_q <= '0;
    end else begin
      p_re_q <= p_re_d;
      p_im_q <= p_im_d;
    end
  end

  assign p_re = p_re_q;
  assign p_im = p_im_q;

endmodule

// File: rtl/fft_bfly_pipe.sv
// rtl/fft_bfly_pipe.sv - 3-stage radix-2 DIT/DIF butterfly with rounding, scale and valid/ready.
// Define BFLY_SAT_EN to clamp out-of-range results; otherwise they wrap to DW bits.
module fft_bfly_pipe
  import fft_pkg::*;
#(
  parameter int DW   = 16,
  parameter int TWW  = 16,
  parameter int FRAC = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           mode,
  input  logic           scale,
  input  logic [DW-1:0]  a_re,
  input  logic [DW-1:0]  a_im,
  input  logic [DW-1:0]  b_re,
  input  logic [DW-1:0]  b_im,
  input  logic [TWW-1:0] tw_re,
  input  logic [TWW-1:0] tw_im,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  y0_re,
  output logic [DW-1:0]  y0_im,
  output logic [DW-1:0]  y1_re,
  output logic [DW-1:0]  y1_im,
  output logic           ovf
);

  localparam int W1 = DW + 1;
  localparam int W2 = DW + 2;
  localparam int W3 = DW + 3;

  logic en;

  logic                  v1_d, v1_q, mode1_d, mode1_q, scale1_d, scale1_q;
  logic signed [DW-1:0]  a1_re_d, a1_re_q, a1_im_d, a1_im_q;
  logic signed [DW-1:0]  b1_re_d, b1_re_q, b1_im_d, b1_im_q;
  logic signed [TWW-1:0] tw1_re_d, tw1_re_q, tw1_im_d, tw1_im_q;

  logic                  v2_d, v2_q, mode2_d, mode2_q, scale2_d, scale2_q;
  logic signed [W1-1:0]  sum_re_d, sum_re_q, sum_im_d, sum_im_q;
  logic signed [W1-1:0]  c_re, c_im, p_re, p_im;

  logic                  out_valid_d, out_valid_q, ovf_d, ovf_q;
  logic [DW-1:0]         y0_re_d, y0_re_q, y0_im_d, y0_im_q;
  logic [DW-1:0]         y1_re_d, y1_re_q, y1_im_d, y1_im_q;

  logic signed [W2-1:0]  r [4];
  logic [DW-1:0]         y_n [4];
  logic signed [W3-1:0]  rs;
  logic signed [31:0]    v32;
  logic                  any_ovf;

  // A stalled output freezes every stage at once; nothing slides into bubbles.
  assign en       = !(out_valid_q && !out_ready);
  assign in_ready = en;

  always_comb begin
    v1_d     = v1_q;
    mode1_d  = mode1_q;
    scale1_d = scale1_q;
    a1_re_d  = a1_re_q;
    a1_im_d  = a1_im_q;
    b1_re_d  = b1_re_q;
    b1_im_d  = b1_im_q;
    tw1_re_d = tw1_re_q;
    tw1_im_d = tw1_im_q;
    if (en) begin
      v1_d     = in_valid;
      mode1_d  = mode;
      scale1_d = scale;
      a1_re_d  = a_re;
      a1_im_d  = a_im;
      b1_re_d  = b_re;
      b1_im_d  = b_im;
      tw1_re_d = tw_re;
      tw1_im_d = tw_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      mode1_q  <= BFLY_DIT;
      scale1_q <= 1'b0;
      a1_re_q  <= '0;
      a1_im_q  <= '0;
      b1_re_q  <= '0;
      b1_im_q  <= '0;
      tw1_re_q <= '0;
      tw1_im_q <= '0;
    end else begin
      v1_q     <= v1_d;
      mode1_q  <= mode1_d;
      scale1_q <= scale1_d;
      a1_re_q  <= a1_re_d;
      a1_im_q  <= a1_im_d;
      b1_re_q  <= b1_re_d;
      b1_im_q  <= b1_im_d;
      tw1_re_q <= tw1_re_d;
      tw1_im_q <= tw1_im_d;
    end
  end

  // DIT multiplies b and forwards a; DIF multiplies a-b and forwards a+b.
  always_comb begin
    v2_d     = v2_q;
    mode2_d  = mode2_q;
    scale2_d = scale2_q;
    sum_re_d = sum_re_q;
    sum_im_d = sum_im_q;
    if (mode1_q == BFLY_DIF) begin
      c_re = W1'(a1_re_q) - W1'(b1_re_q);
      c_im = W1'(a1_im_q) - W1'(b1_im_q);
    end else begin
      c_re = W1'(b1_re_q);
      c_im = W1'(b1_im_q);
    end
    if (en) begin
      v2_d     = v1_q;
      mode2_d  = mode1_q;
      scale2_d = scale1_q;
      if (mode1_q == BFLY_DIF) begin
        sum_re_d = W1'(a1_re_q) + W1'(b1_re_q);
        sum_im_d = W1'(a1_im_q) + W1'(b1_im_q);
      end else begin
        sum_re_d = W1'(a1_re_q);
        sum_im_d = W1'(a1_im_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q     <= 1'b0;
      mode2_q  <= BFLY_DIT;
      scale2_q <= 1'b0;
      sum_re_q <= '0;
      sum_im_q <= '0;
    end else begin
      v2_q     <= v2_d;
      mode2_q  <= mode2_d;
      scale2_q <= scale2_d;
      sum_re_q <= sum_re_d;
      sum_im_q <= sum_im_d;
    end
  end

  cmul_round #(
    .CW   (W1),
    .TWW  (TWW),
    .FRAC (FRAC),
    .OW   (W1)
  ) u_cmul (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .c_re  (c_re),
    .c_im  (c_im),
    .w_re  (tw1_re_q),
    .w_im  (tw1_im_q),
    .p_re  (p_re),
    .p_im  (p_im)
  );

  always_comb begin
    if (mode2_q == BFLY_DIF) begin
      r[0] = W2'(sum_re_q);
      r[1] = W2'(sum_im_q);
      r[2] = W2'(p_re);
      r[3] = W2'(p_im);
    end else begin
      r[0] = W2'(sum_re_q) + W2'(p_re);
      r[1] = W2'(sum_im_q) + W2'(p_im);
      r[2] = W2'(sum_re_q) - W2'(p_re);
      r[3] = W2'(sum_im_q) - W2'(p_im);
    end
    any_ovf = 1'b0;
    rs      = '0;
    v32     = '0;
    for (int i = 0; i < 4; i++) begin
      rs  = scale2_q ? (W3'(r[i]) + W3'(1)) >>> 1 : W3'(r[i]);
      v32 = 32'(rs);
      if (out_of_range(v32, DW)) begin
        any_ovf = 1'b1;
      end
`ifdef BFLY_SAT_EN
      v32 = sat_narrow(v32, DW);
`endif
      y_n[i] = DW'(v32);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    y0_re_d     = y0_re_q;
    y0_im_d     = y0_im_q;
    y1_re_d     = y1_re_q;
    y1_im_d     = y1_im_q;
    if (en) begin
      out_valid_d = v2_q;
      if (v2_q) begin
        ovf_d   = any_ovf;
        y0_re_d = y_n[0];
        y0_im_d = y_n[1];
        y1_re_d = y_n[2];
        y1_im_d = y_n[3];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      y0_re_q     <= '0;
      y0_im_q     <= '0;
      y1_re_q     <= '0;
      y1_im_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      y0_re_q     <= y0_re_d;
      y0_im_q     <= y0_im_d;
      y1_re_q     <= y1_re_d;
      y1_im_q     <= y1_im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign y0_re     = y0_re_q;
  assign y0_im     = y0_im_q;
  assign y1_re     = y1_re_q;
  assign y1_im     = y1_im_q;

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// tb/tb_fft_bfly_pipe.sv - scoreboard bench for fft_bfly_pipe (honours BFLY_SAT_EN).
module tb_fft_bfly_pipe;

  localparam int DW   = 16;
  localparam int TWW  = 16;
  localparam int FRAC = 15;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, mode = 1'b0, scale = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, ovf;
  logic [DW-1:0]  a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic [TWW-1:0] tw_re = '0, tw_im = '0;
  logic [DW-1:0]  y0_re, y0_im, y1_re, y1_im;

  int checks = 0, errors = 0, out_count = 0;
  bit stall_seen = 0, rand_done = 0;

  typedef struct { logic [DW-1:0] y0r, y0i, y1r, y1i; logic ovf; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fft_bfly_pipe #(.DW(DW), .TWW(TWW), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .scale(scale), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .tw_re(tw_re), .tw_im(tw_im), .out_valid(out_valid), .out_ready(out_ready),
    .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic longint wrapn(input longint x, input int n);
    longint m, v;
    m = longint'(1) <<< n;
    v = x % m;
    if (v < 0) v += m;
    if (v >= m / 2) v -= m;
    return v;
  endfunction

  function automatic longint rmul(input longint x);
    return wrapn((x + (longint'(1) <<< (FRAC - 1))) >>> FRAC, DW + 1);
  endfunction

  function automatic exp_t model(input logic md, input logic sc, input longint ar, input longint ai,
                                 input longint br, input longint bi, input longint wr, input longint wi);
    longint r[4];
    longint pr, pi, v, lim;
    logic [63:0] vv;
    logic [DW-1:0] y[4];
    exp_t e;
    lim = longint'(1) <<< (DW - 1);
    if (md) begin
      pr = rmul((ar - br) * wr - (ai - bi) * wi);
      pi = rmul((ar - br) * wi + (ai - bi) * wr);
      r[0] = ar + br; r[1] = ai + bi; r[2] = pr; r[3] = pi;
    end else begin
      pr = rmul(br * wr - bi * wi);
      pi = rmul(br * wi + bi * wr);
      r[0] = ar + pr; r[1] = ai + pi; r[2] = ar - pr; r[3] = ai - pi;
    end
    e.ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = sc ? ((r[i] + 1) >>> 1) : r[i];
      if (v >= lim || v < -lim) begin
        e.ovf = 1'b1;
`ifdef BFLY_SAT_EN
        v = (v >= lim) ? lim - 1 : -lim;
`else
        v = wrapn(v, DW);
`endif
      end
      vv = v;
      y[i] = vv[DW-1:0];
    end
    e.y0r = y[0]; e.y0i = y[1]; e.y1r = y[2]; e.y1i = y[3];
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready)
      sb.push_back(model(mode, scale, longint'($signed(a_re)), longint'($signed(a_im)),
                         longint'($signed(b_re)), longint'($signed(b_im)),
                         longint'($signed(tw_re)), longint'($signed(tw_im))));
  end

  logic stalled_prev = 1'b0;
  logic [2*DW-1:0] prev0, prev1;
  logic [1:0] prevf;
  exp_t e_cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (stalled_prev) begin
        chk("stall_hold_y0", {y0_re, y0_im}, prev0);
        chk("stall_hold_y1", {y1_re, y1_im}, prev1);
        chk("stall_hold_flags", {out_valid, ovf}, prevf);
      end
      if (out_valid && out_ready) begin
        out_count++;
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e_cur = sb.pop_front();
          chk("y0_re", y0_re, e_cur.y0r);
          chk("y0_im", y0_im, e_cur.y0i);
          chk("y1_re", y1_re, e_cur.y1r);
          chk("y1_im", y1_im, e_cur.y1i);
          chk("ovf", ovf, e_cur.ovf);
        end
      end
      if (out_valid && !out_ready) stall_seen = 1;
      stalled_prev = out_valid && !out_ready;
      prev0 = {y0_re, y0_im};
      prev1 = {y1_re, y1_im};
      prevf = {out_valid, ovf};
    end
  end

  task automatic drive(input logic md, input logic sc, input logic [DW-1:0] ar, input logic [DW-1:0] ai,
                       input logic [DW-1:0] br, input logic [DW-1:0] bi,
                       input logic [TWW-1:0] wr, input logic [TWW-1:0] wi);
    int n;
    logic ok;
    mode = md; scale = sc; a_re = ar; a_im = ai; b_re = br; b_im = bi; tw_re = wr; tw_im = wi;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      n++;
      @(posedge clk);
      #1;
    end while (!ok && n < 2000);
    if (!ok) chk("drive_timeout", 0, 1);
  endtask

  task automatic directed(input string name, input logic md, input logic sc,
                          input logic [DW-1:0] ar, input logic [DW-1:0] ai,
                          input logic [DW-1:0] br, input logic [DW-1:0] bi,
                          input logic [TWW-1:0] wr, input logic [TWW-1:0] wi,
                          input logic [DW-1:0] e0r, input logic [DW-1:0] e0i,
                          input logic [DW-1:0] e1r, input logic [DW-1:0] e1i, input logic eo);
    int n;
    drive(md, sc, ar, ai, br, bi, wr, wi);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk({name, "_latency"}, n, 3);
    chk({name, "_y0_re"}, y0_re, e0r);
    chk({name, "_y0_im"}, y0_im, e0i);
    chk({name, "_y1_re"}, y1_re, e1r);
    chk({name, "_y1_im"}, y1_im, e1i);
    chk({name, "_ovf"}, ovf, eo);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  function automatic logic [DW-1:0] rdat();
    int k;
    k = $urandom_range(0, 7);
    if (k == 0) return {1'b0, {(DW-1){1'b1}}};
    if (k == 1) return {1'b1, {(DW-1){1'b0}}};
    return DW'($urandom);
  endfunction

  function automatic logic [TWW-1:0] rtw();
    int k;
    k = $urandom_range(0, 7);
    if (k == 0) return {1'b0, {(TWW-1){1'b1}}};
    if (k == 1) return {1'b1, {(TWW-1){1'b0}}};
    return TWW'($urandom);
  endfunction

  exp_t m;
  int base, quiet;

  initial begin
    m = model(0, 0, 100, 0, 200, 0, 16384, 0);
    chk("model_dit_y0", m.y0r, 16'd200);
    chk("model_dit_y1", m.y1r, 16'd0);
    m = model(1, 0, 300, 50, 100, 10, 0, 16384);
    chk("model_dif_y1", {m.y1r, m.y1i}, {16'hFFEC, 16'd100});
    m = model(0, 1, 3, 0, 0, 0, 16384, 0);
    chk("model_scale", {m.y0r, m.y1r}, {16'd2, 16'd2});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {y0_re, y0_im, y1_re, y1_im, ovf}, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("dit_basic", 0, 0, 16'd100, 16'd0, 16'd200, 16'd0, 16'h4000, 16'h0,
             16'd200, 16'd0, 16'd0, 16'd0, 1'b0);
    directed("dif_basic", 1, 0, 16'd300, 16'd50, 16'd100, 16'd10, 16'h0, 16'h4000,
             16'd400, 16'd60, 16'hFFEC, 16'd100, 1'b0);
`ifdef BFLY_SAT_EN
    directed("overflow", 0, 0, 16'h7000, 16'h0, 16'h7000, 16'h0, 16'h4000, 16'h0,
             16'h7FFF, 16'h0, 16'h3800, 16'h0, 1'b1);
`else
    directed("overflow", 0, 0, 16'h7000, 16'h0, 16'h7000, 16'h0, 16'h4000, 16'h0,
             16'hA800, 16'h0, 16'h3800, 16'h0, 1'b1);
`endif
    directed("scale", 0, 1, 16'd3, 16'd0, 16'd0, 16'd0, 16'h4000, 16'h0,
             16'd2, 16'd0, 16'd2, 16'd0, 1'b0);

    base = out_count;
    stall_seen = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          drive(1'($urandom), 1'($urandom), rdat(), rdat(), rdat(), rdat(), rtw(), rtw());
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_stall_seen", stall_seen, 1);
    chk("bp_count", out_count - base, 8);

    base = out_count;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          drive(1'($urandom), 1'($urandom), rdat(), rdat(), rdat(), rdat(), rtw(), rtw());
        end
        in_valid = 1'b0;
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("rand_count", out_count - base, 400);

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      drive(1'($urandom), 1'($urandom), rdat(), rdat(), rdat(), rdat(), rtw(), rtw());
    in_valid = 1'b0;
    chk("inflight_valid", out_valid, 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_outputs", {y0_re, y0_im, y1_re, y1_im, ovf}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) quiet++;
    end
    chk("post_rst_no_output", quiet, 0);
    chk("post_rst_in_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
